// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for instr_decode_stage.
// slave: the decode stage's view. master: the driver/consumer view.
interface instr_decode_stage_if #(
    parameter int REG_W = 4,
    parameter int PC_W  = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             restart;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_class;
    logic [3:0]       out_cond;
    logic [3:0]       out_opcode;
    logic             out_set_cond;
    logic [REG_W-1:0] out_rn;
    logic [REG_W-1:0] out_rd;
    logic [REG_W-1:0] out_rm;
    logic             out_imm_sel;
    logic [31:0]      out_imm;
    logic [7:0]       out_shift;
    logic             out_mem_load;
    logic             out_mem_up;
    logic [11:0]      out_mem_offset;
    logic             out_branch_link;
    logic [31:0]      out_branch_off;
    logic [PC_W-1:0]  out_pc;
    logic             halted;
    logic [15:0]      cnt_alu;
    logic [15:0]      cnt_mem;
    logic [15:0]      cnt_branch;
    logic [15:0]      cnt_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, restart, out_ready,
        output in_ready, out_valid, out_class, out_cond, out_opcode, out_set_cond,
               out_rn, out_rd, out_rm, out_imm_sel, out_imm, out_shift,
               out_mem_load, out_mem_up, out_mem_offset, out_branch_link,
               out_branch_off, out_pc, halted,
               cnt_alu, cnt_mem, cnt_branch, cnt_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, restart, out_ready,
        input  in_ready, out_valid, out_class, out_cond, out_opcode, out_set_cond,
               out_rn, out_rd, out_rm, out_imm_sel, out_imm, out_shift,
               out_mem_load, out_mem_up, out_mem_offset, out_branch_link,
               out_branch_off, out_pc, halted,
               cnt_alu, cnt_mem, cnt_branch, cnt_illegal
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: decodes ARM-style words into a micro-op, buffers
// micro-ops in a FIFO_DEPTH-entry output FIFO, halts on the all-zero word.
// Optional: DECODE_PERF_CNT_EN builds saturating per-class decode counters;
// without it the cnt_* outputs are tied to zero.
module instr_decode_stage #(
    parameter int REG_W      = 4,
    parameter int PC_W       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    instr_decode_stage_if.slave bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_BX      = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } cls_e;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    typedef struct packed {
        cls_e             cls;
        logic [3:0]       cond;
        logic [3:0]       opcode;
        logic             set_cond;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rm;
        logic             imm_sel;
        logic [31:0]      imm;
        logic [7:0]       shift;
        logic             mem_load;
        logic             mem_up;
        logic [11:0]      mem_offset;
        logic             branch_link;
        logic [31:0]      branch_off;
        logic [PC_W-1:0]  pc;
    } entry_t;

    state_e           state, state_nx;
    entry_t           dec;
    entry_t           head;
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop;
    logic [4:0]       rot;
    logic [31:0]      imm8;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign full          = (count == CNT_W'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign bus.in_ready  = (state == ST_RUN) && !full;
    assign bus.out_valid = !empty;
    // flush wins over both sides, so neither handshake takes effect under it
    assign push          = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = !empty && bus.out_ready && !bus.flush;
    assign bus.halted    = (state == ST_HALTED);

    // Decode the offered word into a fully populated entry; unused fields stay 0
    always_comb begin
        dec      = '0;
        dec.cls  = CLS_ALU;
        dec.cond = bus.in_instr[31:28];
        dec.pc   = bus.in_pc;
        rot      = {bus.in_instr[11:8], 1'b0};
        imm8     = {24'd0, bus.in_instr[7:0]};
        if (bus.in_instr == '0) begin
            dec.cls = CLS_HALT;
        end else if (bus.in_instr[27:4] == 24'h12FFF1) begin
            dec.cls = CLS_BX;
            dec.rm  = REG_W'(bus.in_instr[3:0]);
        end else if (bus.in_instr[27:26] == 2'b00) begin
            dec.cls      = CLS_ALU;
            dec.opcode   = bus.in_instr[24:21];
            dec.set_cond = bus.in_instr[20];
            dec.rn       = REG_W'(bus.in_instr[19:16]);
            dec.rd       = REG_W'(bus.in_instr[15:12]);
            dec.imm_sel  = bus.in_instr[25];
            if (bus.in_instr[25]) begin
                // shift by 32 yields 0, so rot==0 leaves imm8 unchanged
                dec.imm = (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));
            end else begin
                dec.rm    = REG_W'(bus.in_instr[3:0]);
                dec.shift = bus.in_instr[11:4];
            end
        end else if (bus.in_instr[27:25] == 3'b010) begin
            dec.cls        = CLS_MEM;
            dec.mem_load   = bus.in_instr[20];
            dec.mem_up     = bus.in_instr[23];
            dec.rn         = REG_W'(bus.in_instr[19:16]);
            dec.rd         = REG_W'(bus.in_instr[15:12]);
            dec.mem_offset = bus.in_instr[11:0];
        end else if (bus.in_instr[27:25] == 3'b101) begin
            dec.cls         = CLS_BRANCH;
            dec.branch_link = bus.in_instr[24];
            dec.branch_off  = {{6{bus.in_instr[23]}}, bus.in_instr[23:0], 2'b00};
        end else begin
            dec.cls = CLS_ILLEGAL;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Run/halt state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nx;
    end

    // Run/halt next state: halt once a HALT word is accepted, resume on restart
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:    if (push && dec.cls == CLS_HALT) state_nx = ST_HALTED;
            ST_HALTED: if (bus.restart) state_nx = ST_RUN;
            default:   state_nx = ST_RUN;
        endcase
    end

    // Head entry presented to the consumer; all zero while the FIFO is empty
    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr];
    end

    assign bus.out_class       = head.cls;
    assign bus.out_cond        = head.cond;
    assign bus.out_opcode      = head.opcode;
    assign bus.out_set_cond    = head.set_cond;
    assign bus.out_rn          = head.rn;
    assign bus.out_rd          = head.rd;
    assign bus.out_rm          = head.rm;
    assign bus.out_imm_sel     = head.imm_sel;
    assign bus.out_imm         = head.imm;
    assign bus.out_shift       = head.shift;
    assign bus.out_mem_load    = head.mem_load;
    assign bus.out_mem_up      = head.mem_up;
    assign bus.out_mem_offset  = head.mem_offset;
    assign bus.out_branch_link = head.branch_link;
    assign bus.out_branch_off  = head.branch_off;
    assign bus.out_pc          = head.pc;

`ifdef DECODE_PERF_CNT_EN
    logic [15:0] c_alu, c_mem, c_branch, c_illegal;

    // Saturating per-class counters of accepted words; flush does not touch them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_alu     <= '0;
            c_mem     <= '0;
            c_branch  <= '0;
            c_illegal <= '0;
        end else if (push) begin
            if (dec.cls == CLS_ALU && c_alu != '1)         c_alu     <= c_alu + 16'd1;
            if (dec.cls == CLS_MEM && c_mem != '1)         c_mem     <= c_mem + 16'd1;
            if (dec.cls == CLS_BRANCH && c_branch != '1)   c_branch  <= c_branch + 16'd1;
            if (dec.cls == CLS_ILLEGAL && c_illegal != '1) c_illegal <= c_illegal + 16'd1;
        end
    end

    assign bus.cnt_alu     = c_alu;
    assign bus.cnt_mem     = c_mem;
    assign bus.cnt_branch  = c_branch;
    assign bus.cnt_illegal = c_illegal;
`else
    assign bus.cnt_alu     = '0;
    assign bus.cnt_mem     = '0;
    assign bus.cnt_branch  = '0;
    assign bus.cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: expected micro-ops are queued
// when a word is accepted and compared when the consumer takes the head.
module tb_instr_decode_stage;
    localparam int REG_W = 4;
    localparam int PC_W  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [2:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        set_cond;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic        imm_sel;
        logic [31:0] imm;
        logic [7:0]  shift;
        logic        load;
        logic        up;
        logic [11:0] offset;
        logic        link;
        logic [31:0] boff;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int unsigned m_alu = 0, m_mem = 0, m_branch = 0, m_illegal = 0;

    always #5 clk = ~clk;

    instr_decode_stage_if #(.REG_W(REG_W), .PC_W(PC_W)) bus ();

    instr_decode_stage #(.REG_W(REG_W), .PC_W(PC_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e = '0;
        logic [31:0] r;
        e.pc   = pc;
        e.cond = w[31:28];
        if (w == 32'd0) begin
            e.cls = 3'd4;
        end else if (w[27:4] == 24'h12FFF1) begin
            e.cls = 3'd2;
            e.rm  = w[3:0];
        end else if (w[27:26] == 2'b00) begin
            e.cls      = 3'd0;
            e.opcode   = w[24:21];
            e.set_cond = w[20];
            e.rn       = w[19:16];
            e.rd       = w[15:12];
            e.imm_sel  = w[25];
            if (w[25]) begin
                r = {24'd0, w[7:0]};
                for (int i = 0; i < 2 * int'(w[11:8]); i++) r = {r[0], r[31:1]};
                e.imm = r;
            end else begin
                e.rm    = w[3:0];
                e.shift = w[11:4];
            end
        end else if (w[27:26] == 2'b01 && !w[25]) begin
            e.cls    = 3'd1;
            e.load   = w[20];
            e.up     = w[23];
            e.rn     = w[19:16];
            e.rd     = w[15:12];
            e.offset = w[11:0];
        end else if (w[27:25] == 3'b101) begin
            e.cls  = 3'd3;
            e.link = w[24];
            r      = {{8{w[23]}}, w[23:0]};
            e.boff = r << 2;
        end else begin
            e.cls = 3'd5;
        end
        return e;
    endfunction

    function automatic exp_t sample_out();
        return {bus.out_class, bus.out_cond, bus.out_opcode, bus.out_set_cond,
                bus.out_rn, bus.out_rd, bus.out_rm, bus.out_imm_sel, bus.out_imm,
                bus.out_shift, bus.out_mem_load, bus.out_mem_up, bus.out_mem_offset,
                bus.out_branch_link, bus.out_branch_off, bus.out_pc};
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= 32'hFFFF) ? 32'hFFFF : v + 1;
    endfunction

    task automatic model_count(input logic [2:0] c);
        case (c)
            3'd0: m_alu     = sat_inc(m_alu);
            3'd1: m_mem     = sat_inc(m_mem);
            3'd3: m_branch  = sat_inc(m_branch);
            3'd5: m_illegal = sat_inc(m_illegal);
            default: ;
        endcase
    endtask

    task automatic check_counters(input string tag);
`ifdef DECODE_PERF_CNT_EN
        check({tag, "_cnt_alu"},     bus.cnt_alu,     m_alu[15:0]);
        check({tag, "_cnt_mem"},     bus.cnt_mem,     m_mem[15:0]);
        check({tag, "_cnt_branch"},  bus.cnt_branch,  m_branch[15:0]);
        check({tag, "_cnt_illegal"}, bus.cnt_illegal, m_illegal[15:0]);
`else
        check({tag, "_cnt_alu"},     bus.cnt_alu,     16'd0);
        check({tag, "_cnt_mem"},     bus.cnt_mem,     16'd0);
        check({tag, "_cnt_branch"},  bus.cnt_branch,  16'd0);
        check({tag, "_cnt_illegal"}, bus.cnt_illegal, 16'd0);
`endif
    endtask

    // Called #1 after a posedge; returns #1 after the edge that accepted the word
    task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        bus.in_pc    = pc;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", bus.in_ready, 1'b1);
        if (bus.in_ready) begin
            e = ref_decode(w, pc);
            sb.push_back(e);
            model_count(e.cls);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Consumer side: compare every delivered head against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
            check("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("entry", sample_out(), e);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.restart   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #2;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_fields", sample_out(), '0);
        check_counters("rst");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;

        // MOV r1,#5: visible one cycle after the push
        push_word(32'hE3A01005, 32'h100);
        @(negedge clk);
        check("lat_out_valid", bus.out_valid, 1'b1);
        check("mov_class", bus.out_class, 3'd0);
        check("mov_cond", bus.out_cond, 4'hE);
        check("mov_opcode", bus.out_opcode, 4'hD);
        check("mov_rd", bus.out_rd, 4'd1);
        check("mov_imm", bus.out_imm, 32'h5);
        @(posedge clk);
        #1;

        // back-to-back ALU rotated immediate, MEM, BX
        push_word(32'hE2821C01, 32'h104);
        push_word(32'hE5912004, 32'h108);
        push_word(32'hE12FFF1E, 32'h10C);
        push_word(32'hE1A01002, 32'h110);
        drain();

        // BL with negative offset
        push_word(32'hEBFFFFFE, 32'h114);
        @(negedge clk);
        check("bl_class", bus.out_class, 3'd3);
        check("bl_link", bus.out_branch_link, 1'b1);
        check("bl_off", bus.out_branch_off, 32'hFFFFFFF8);
        @(posedge clk);
        #1;
        push_word(32'hEE000000, 32'h118);
        push_word(32'h0A000010, 32'h11C);
        drain();
        check_counters("mid");

        // fill, back-pressure, then flush
        bus.out_ready = 1'b0;
        push_word(32'hE3A02007, 32'h200);
        push_word(32'hE5912004, 32'h204);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hE3A03009;
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_out_valid", bus.out_valid, 1'b1);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_in_ready", bus.in_ready, 1'b1);
        check_counters("flush");
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // HALT, blocked fetch, restart
        push_word(32'h00000000, 32'h300);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hE3A01005;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_halted", bus.halted, 1'b1);
            check("halt_in_ready", bus.in_ready, 1'b0);
        end
        check("halt_delivered", sb.size(), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.restart  = 1'b1;
        @(posedge clk);
        #1;
        bus.restart = 1'b0;
        @(negedge clk);
        check("restart_halted", bus.halted, 1'b0);
        check("restart_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.restart = 1'b1;
        @(posedge clk);
        #1;
        bus.restart = 1'b0;
        check("run_restart_ignored", bus.halted, 1'b0);
        push_word(32'hE0812003, 32'h304);
        drain();

`ifdef DECODE_PERF_CNT_EN
        // drive the MEM counter past its ceiling
        while (m_mem < 32'hFFFF + 3) begin
            if (m_mem == 32'hFFFF) break;
            push_word(32'hE5912004, 32'h400);
        end
        for (int i = 0; i < 3; i++) push_word(32'hE5912004, 32'h404);
        drain();
        check("sat_cnt_mem", bus.cnt_mem, 16'hFFFF);
`endif
        check_counters("end");

        // asynchronous reset with entries in flight
        bus.out_ready = 1'b0;
        push_word(32'hE3A01005, 32'h500);
        push_word(32'hEE000000, 32'h504);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        m_alu = 0; m_mem = 0; m_branch = 0; m_illegal = 0;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_halted", bus.halted, 1'b0);
        check_counters("arst");
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push_word(32'hE2821C01, 32'h600);
        drain();
        check_counters("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
